// File: rtl/efuse_sched.sv
`default_nettype none
// ============================================================================
// Module   : efuse_sched
// Purpose  : Shares the eFuse controller between boot, host and debug ports.
//            Optional sticky program lock: EFUSE_SCHED_PGM_LOCK_EN.
// Revision : 1.0
// ============================================================================
module efuse_sched #(
  parameter int CMD_HOLD   = 4,
  parameter int GAP_CYC    = 4,
  parameter int RD_TIMEOUT = 1023,
  parameter int PGM_WAIT   = 2047,
  parameter int BOOT_EN    = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_host_req,
  input  logic [1:0]  i_host_op,
  output logic        o_host_ack,
  input  logic        i_dbg_req,
  input  logic [1:0]  i_dbg_op,
  output logic        o_dbg_ack,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_ef_cmd_read,
  output logic        o_ef_cmd_pgm,
  output logic        o_ef_cmd_init,
  input  logic        i_ef_read_done,
  input  logic [63:0] i_ef_rdata,
  input  logic        i_ef_read_fail,
  output logic [63:0] o_shadow,
  output logic        o_shadow_vld,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BOOT     = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RD  = 3'd3,
    S_WAIT_PGM = 3'd4,
    S_RESP     = 3'd5,
    S_GAP      = 3'd6
  } state_t;

  localparam logic [1:0]  c_OP_READ   = 2'b00;
  localparam logic [1:0]  c_OP_PGM    = 2'b01;
  localparam logic [1:0]  c_OP_INIT   = 2'b10;
  localparam logic [1:0]  c_OP_RSVD   = 2'b11;
  localparam logic [15:0] c_HOLD_LAST = 16'(CMD_HOLD - 1);
  localparam logic [15:0] c_GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [15:0] c_RD_LAST   = 16'(RD_TIMEOUT - 1);
  localparam logic [15:0] c_PGM_LAST  = 16'(PGM_WAIT - 1);
  localparam state_t      c_RST_STATE = (BOOT_EN != 0) ? S_BOOT : S_IDLE;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        dbg_sel_q, dbg_sel_d;
  logic        boot_q, boot_d;
  logic        last_dbg_q, last_dbg_d;
  logic        host_blk_q, host_blk_d;
  logic        dbg_blk_q, dbg_blk_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [63:0] shadow_q, shadow_d;
  logic        shadow_vld_q, shadow_vld_d;
  logic        busy_q;

  logic        w_host_ok, w_dbg_ok, w_pick_dbg;
  logic [1:0]  w_op;
  logic        w_lock_set, w_pgm_locked;
  logic        w_host_ack, w_dbg_ack, w_issue;

  // A requester must drop its req once after an ack before it is eligible again
  assign w_host_ok  = i_host_req && !host_blk_q;
  assign w_dbg_ok   = i_dbg_req && !dbg_blk_q;
  assign w_host_ack = (state_q == S_RESP) && !boot_q && !dbg_sel_q;
  assign w_dbg_ack  = (state_q == S_RESP) && !boot_q && dbg_sel_q;
  assign host_blk_d = w_host_ack | (host_blk_q & i_host_req);
  assign dbg_blk_d  = w_dbg_ack | (dbg_blk_q & i_dbg_req);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dbg_sel_d    = dbg_sel_q;
    boot_d       = boot_q;
    last_dbg_d   = last_dbg_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    w_lock_set   = 1'b0;
    w_pick_dbg   = 1'b0;
    w_op         = i_host_op;
    case (state_q)
      S_BOOT: begin
        boot_d  = 1'b1;
        op_d    = c_OP_READ;
        state_d = S_ISSUE;
      end
      S_IDLE: begin
        if (w_host_ok || w_dbg_ok) begin
          w_pick_dbg = w_dbg_ok && (!w_host_ok || !last_dbg_q);
          w_op       = w_pick_dbg ? i_dbg_op : i_host_op;
          op_d       = w_op;
          dbg_sel_d  = w_pick_dbg;
          last_dbg_d = w_pick_dbg;
          if (w_op == c_OP_RSVD || (w_op == c_OP_PGM && w_pgm_locked)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == c_HOLD_LAST) begin
          if (op_q == c_OP_PGM) begin
            state_d      = S_WAIT_PGM;
            shadow_vld_d = 1'b0;
          end else begin
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        // Done wins over a timeout landing in the same cycle
        if (i_ef_read_done) begin
          if (op_q == c_OP_READ || !i_ef_read_fail) begin
            shadow_d     = i_ef_rdata;
            shadow_vld_d = 1'b1;
          end
          if (!boot_q) begin
            rdata_d = i_ef_rdata;
            err_d   = (op_q == c_OP_INIT) && i_ef_read_fail;
          end
          state_d = S_RESP;
        end else if (cnt_q == c_RD_LAST) begin
          if (!boot_q) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_WAIT_PGM: begin
        if (cnt_q == c_PGM_LAST) begin
          rdata_d    = '0;
          err_d      = 1'b0;
          w_lock_set = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          boot_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'd1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= c_RST_STATE;
      cnt_q        <= '0;
      op_q         <= c_OP_READ;
      dbg_sel_q    <= 1'b0;
      boot_q       <= 1'b0;
      last_dbg_q   <= 1'b1;
      host_blk_q   <= 1'b0;
      dbg_blk_q    <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      dbg_sel_q    <= dbg_sel_d;
      boot_q       <= boot_d;
      last_dbg_q   <= last_dbg_d;
      host_blk_q   <= host_blk_d;
      dbg_blk_q    <= dbg_blk_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

`ifdef EFUSE_SCHED_PGM_LOCK_EN
  logic lock_q;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lock_q <= 1'b0;
    end else if (w_lock_set) begin
      lock_q <= 1'b1;
    end
  end
  assign w_pgm_locked = lock_q;
`else
  logic w_unused_lock;
  assign w_unused_lock = w_lock_set;
  assign w_pgm_locked  = 1'b0;
`endif

  assign w_issue       = (state_q == S_ISSUE);
  assign o_ef_cmd_read = w_issue && (op_q == c_OP_READ);
  assign o_ef_cmd_pgm  = w_issue && (op_q == c_OP_PGM);
  assign o_ef_cmd_init = w_issue && (op_q == c_OP_INIT);
  assign o_host_ack    = w_host_ack;
  assign o_dbg_ack     = w_dbg_ack;
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_err     = err_q;
  assign o_shadow      = shadow_q;
  assign o_shadow_vld  = shadow_vld_q;
  assign o_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_efuse_sched.sv
`default_nettype none
// Scoreboard bench for efuse_sched: random host/debug traffic against a
// transaction-level model of responses, shadow state and command timing.
module tb_efuse_sched;
  localparam int CMD_HOLD   = 4;
  localparam int GAP_CYC    = 4;
  localparam int RD_TIMEOUT = 1023;
  localparam int PGM_WAIT   = 2047;
`ifdef EFUSE_SCHED_PGM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_host_req, i_dbg_req;
  logic [1:0]  i_host_op, i_dbg_op;
  logic        o_host_ack, o_dbg_ack;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_ef_cmd_read, o_ef_cmd_pgm, o_ef_cmd_init;
  logic        i_ef_read_done;
  logic [63:0] i_ef_rdata;
  logic        i_ef_read_fail;
  logic [63:0] o_shadow;
  logic        o_shadow_vld, o_busy;

  efuse_sched #(
    .CMD_HOLD(CMD_HOLD), .GAP_CYC(GAP_CYC), .RD_TIMEOUT(RD_TIMEOUT),
    .PGM_WAIT(PGM_WAIT), .BOOT_EN(1)
  ) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_host_req(i_host_req), .i_host_op(i_host_op), .o_host_ack(o_host_ack),
    .i_dbg_req(i_dbg_req), .i_dbg_op(i_dbg_op), .o_dbg_ack(o_dbg_ack),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_ef_cmd_read(o_ef_cmd_read), .o_ef_cmd_pgm(o_ef_cmd_pgm), .o_ef_cmd_init(o_ef_cmd_init),
    .i_ef_read_done(i_ef_read_done), .i_ef_rdata(i_ef_rdata), .i_ef_read_fail(i_ef_read_fail),
    .o_shadow(o_shadow), .o_shadow_vld(o_shadow_vld), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          dbg;
    bit          err;
    logic [63:0] rdata;
    bit          svld;
    logic [63:0] shadow;
  } exp_t;

  typedef struct {
    bit          respond;
    int          delay;
    logic [63:0] data;
    bit          fail;
  } ctl_t;

  exp_t sb_q[$];
  ctl_t ctl_q[$];

  int checks = 0, errors = 0;
  int acks = 0, host_acks = 0, dbg_acks = 0;
  int n_rd = 0, n_pgm = 0, n_init = 0;

  logic [63:0] m_shadow;
  bit          m_svld, m_locked, m_last_dbg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: what the requester must see and what the shadow must hold
  task automatic plan(input bit dbg, input logic [1:0] op, input bit respond,
                      input bit fail, input logic [63:0] data);
    exp_t e;
    ctl_t c;
    e.dbg = dbg; e.err = 1'b0; e.rdata = '0;
    case (op)
      2'b00, 2'b10: begin
        c.respond = respond; c.delay = int'($urandom_range(5, 40));
        c.data = data; c.fail = fail;
        ctl_q.push_back(c);
        if (!respond) begin
          e.err = 1'b1;
        end else begin
          e.rdata = data;
          e.err   = (op == 2'b10) && fail;
          if (!e.err) begin m_shadow = data; m_svld = 1'b1; end
        end
      end
      2'b01: begin
        if (LOCK_EN && m_locked) e.err = 1'b1;
        else begin m_svld = 1'b0; if (LOCK_EN) m_locked = 1'b1; end
      end
      default: e.err = 1'b1;
    endcase
    e.svld = m_svld; e.shadow = m_shadow;
    sb_q.push_back(e);
  endtask

  // Controller stand-in: answers read/init edges in issue order
  initial begin : ctl_model
    ctl_t c;
    bit   prev, cur;
    i_ef_read_done = 1'b0; i_ef_read_fail = 1'b0; i_ef_rdata = '0; prev = 1'b0;
    forever begin
      @(negedge clk);
      i_ef_rdata = {$urandom, $urandom}; i_ef_read_fail = 1'($urandom);
      cur = o_ef_cmd_read || o_ef_cmd_init;
      if (rstn && cur && !prev) begin
        if (ctl_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: read=%0b init=%0b issued with none expected", o_ef_cmd_read, o_ef_cmd_init);
        end else begin
          c = ctl_q.pop_front();
          if (c.respond) begin
            repeat (c.delay) begin @(negedge clk); i_ef_rdata = {$urandom, $urandom}; end
            i_ef_read_done = 1'b1; i_ef_rdata = c.data; i_ef_read_fail = c.fail;
            @(negedge clk);
            i_ef_read_done = 1'b0;
          end
        end
      end
      prev = o_ef_cmd_read || o_ef_cmd_init;
    end
  end

  initial begin : cmd_mon
    logic [2:0] prev, cur;
    int run[3];
    int low_run;
    bit first;
    prev = '0; low_run = 0; first = 1'b1;
    for (int i = 0; i < 3; i++) run[i] = 0;
    forever begin
      @(negedge clk);
      cur = {o_ef_cmd_init, o_ef_cmd_pgm, o_ef_cmd_read};
      if (!rstn) begin
        prev = '0; low_run = 0; first = 1'b1;
      end else begin
        if (cur != 3'b000) chk("cmd_onehot", 64'($countones(cur)), 64'd1);
        if (cur != 3'b000 && prev == 3'b000) begin
          if (!first) chk("cmd_gap_ok", 64'(low_run >= GAP_CYC), 64'd1);
          first = 1'b0;
          if (cur[0]) n_rd++;
          if (cur[1]) n_pgm++;
          if (cur[2]) n_init++;
        end
        for (int i = 0; i < 3; i++) begin
          if (cur[i]) run[i]++;
          else if (prev[i]) begin chk("cmd_hold", 64'(run[i]), 64'(CMD_HOLD)); run[i] = 0; end
        end
        low_run = (cur == 3'b000) ? low_run + 1 : 0;
        prev = cur;
      end
    end
  end

  initial begin : ack_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && (o_host_ack || o_dbg_ack)) begin
        acks++;
        if (o_host_ack) host_acks++;
        if (o_dbg_ack) dbg_acks++;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: host=%0b dbg=%0b with nothing expected", o_host_ack, o_dbg_ack);
        end else begin
          e = sb_q.pop_front();
          chk("ack_who", 64'({o_dbg_ack, o_host_ack}), e.dbg ? 64'd2 : 64'd1);
          chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
          chk("rsp_rdata", o_rsp_rdata, e.rdata);
          chk("shadow_vld", 64'(o_shadow_vld), 64'(e.svld));
          if (e.svld) chk("shadow", o_shadow, e.shadow);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int g = 0;
    while (o_busy && g < budget) begin @(posedge clk); #1; g++; end
    if (o_busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", o_busy, budget);
    end
  endtask

  task automatic single(input bit dbg, input logic [1:0] op, input bit respond, input bit fail);
    logic [63:0] data;
    int a0, start, lat, r0, p0, i0;
    bit rejected;
    data = {$urandom, $urandom};
    rejected = (op == 2'b11) || (op == 2'b01 && LOCK_EN && m_locked);
    plan(dbg, op, respond, fail, data);
    m_last_dbg = dbg;
    a0 = acks; r0 = n_rd; p0 = n_pgm; i0 = n_init; start = cyc;
    if (dbg) begin i_dbg_op = op; i_dbg_req = 1'b1; end
    else begin i_host_op = op; i_host_req = 1'b1; end
    while (acks == a0 && (cyc - start) < 6000) begin @(posedge clk); #1; end
    lat = cyc - start;
    i_host_req = 1'b0; i_dbg_req = 1'b0;
    if (acks == a0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack after %0d cycles for op %0d", lat, op);
      sb_q.delete(); ctl_q.delete();
    end
    chk("rd_rises", 64'(n_rd - r0), 64'(op == 2'b00));
    chk("pgm_rises", 64'(n_pgm - p0), 64'(op == 2'b01 && !rejected));
    chk("init_rises", 64'(n_init - i0), 64'(op == 2'b10));
    if (rejected) chk("reject_latency_ok", 64'(lat <= 3), 64'd1);
    else if (op == 2'b01) chk("pgm_latency_ok", 64'(lat >= PGM_WAIT), 64'd1);
    else if (!respond) chk("timeout_latency_ok", 64'(lat >= RD_TIMEOUT), 64'd1);
    wait_idle(100);
  endtask

  task automatic pair(input logic [1:0] hop, input logic [1:0] dop);
    logic [63:0] hd, dd;
    int h0, d0, start;
    bit hf, df;
    hd = {$urandom, $urandom}; dd = {$urandom, $urandom};
    hf = 1'($urandom); df = 1'($urandom);
    if (!m_last_dbg) begin
      plan(1'b1, dop, 1'b1, df, dd); plan(1'b0, hop, 1'b1, hf, hd); m_last_dbg = 1'b0;
    end else begin
      plan(1'b0, hop, 1'b1, hf, hd); plan(1'b1, dop, 1'b1, df, dd); m_last_dbg = 1'b1;
    end
    h0 = host_acks; d0 = dbg_acks; start = cyc;
    i_host_op = hop; i_dbg_op = dop; i_host_req = 1'b1; i_dbg_req = 1'b1;
    while ((i_host_req || i_dbg_req) && (cyc - start) < 12000) begin
      @(posedge clk); #1;
      if (host_acks != h0) i_host_req = 1'b0;
      if (dbg_acks != d0) i_dbg_req = 1'b0;
    end
    if (i_host_req || i_dbg_req) begin
      checks++; errors++;
      $display("FAIL pair_timeout: host_req=%0b dbg_req=%0b still pending", i_host_req, i_dbg_req);
      i_host_req = 1'b0; i_dbg_req = 1'b0; sb_q.delete(); ctl_q.delete();
    end
    wait_idle(100);
  endtask

  function automatic logic [1:0] rand_op();
    int r = int'($urandom_range(0, 15));
    if (r < 6) return 2'b00;
    if (r < 11) return 2'b10;
    if (r < 13) return 2'b11;
    return 2'b01;
  endfunction

  initial begin : main
    ctl_t c;
    int g, k;
    rstn = 1'b0; i_host_req = 1'b0; i_dbg_req = 1'b0; i_host_op = 2'b00; i_dbg_op = 2'b00;
    m_shadow = '0; m_svld = 1'b0; m_locked = 1'b0; m_last_dbg = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_ack", 64'(o_host_ack), 64'd0);
    chk("rst_dbg_ack", 64'(o_dbg_ack), 64'd0);
    chk("rst_rdata", o_rsp_rdata, 64'd0);
    chk("rst_err", 64'(o_rsp_err), 64'd0);
    chk("rst_cmds", 64'({o_ef_cmd_read, o_ef_cmd_pgm, o_ef_cmd_init}), 64'd0);
    chk("rst_shadow", o_shadow, 64'd0);
    chk("rst_shadow_vld", 64'(o_shadow_vld), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);

    c.respond = 1'b1; c.delay = 26; c.data = 64'hDEAD_BEEF_0123_4567; c.fail = 1'b0;
    ctl_q.push_back(c);
    m_shadow = 64'hDEAD_BEEF_0123_4567; m_svld = 1'b1;
    rstn = 1'b1;
    g = 0;
    while (!o_busy && g < 20) begin @(posedge clk); #1; g++; end
    chk("boot_busy_rise", 64'(o_busy), 64'd1);
    wait_idle(3000);
    chk("boot_shadow", o_shadow, 64'hDEAD_BEEF_0123_4567);
    chk("boot_shadow_vld", 64'(o_shadow_vld), 64'd1);
    chk("boot_busy_low", 64'(o_busy), 64'd0);
    chk("boot_no_ack", 64'(acks), 64'd0);
    chk("boot_rd_rises", 64'(n_rd), 64'd1);

    pair(2'b00, 2'b00);
    single(1'b0, 2'b01, 1'b1, 1'b0);
    single(1'b1, 2'b00, 1'b1, 1'b0);
    single(1'b1, 2'b10, 1'b1, 1'b1);
    single(1'b0, 2'b00, 1'b0, 1'b0);
    single(1'b0, 2'b11, 1'b1, 1'b0);
    single(1'b0, 2'b01, 1'b1, 1'b0);
    single(1'b1, 2'b00, 1'b1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      k = int'($urandom_range(0, 9));
      if (k < 3) pair(rand_op(), rand_op());
      else single(k[0], rand_op(), 1'b1, 1'($urandom));
    end

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("ctl_drained", 64'(ctl_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/efuse_sched.md
Name: efuse_sched

Overview:
- Sequences and shares the 64-bit eFuse controller between an internal boot loader, a host register port and a debug port.
- Issues level commands (read / program / init) with guaranteed hold and gap timing, so the controller's rising-edge detectors see one clean edge per operation.
- Waits for completion by done pulse or fixed timer and returns result and status to the requester.
- Keeps a shadow copy of the last good fuse read for downstream consumers.

Parameters:
CMD_HOLD, 4, cycles a command line is held high (min 3)
GAP_CYC, 4, cycles all command lines stay low between operations (min 3)
RD_TIMEOUT, 1023, cycles allowed for read/init done before error
PGM_WAIT, 2047, fixed cycles waited after a program command
BOOT_EN, 1, 1 = automatic read after reset

Ports:
i_clk  in  1  clock
i_rstn  in  1  async active-low reset
i_host_req  in  1  host request, level, held until ack
i_host_op  in  2  00 read, 01 program, 10 init, 11 reserved
o_host_ack  out  1  one-cycle completion pulse to host
i_dbg_req  in  1  debug request, level
i_dbg_op  in  2  same encoding as host
o_dbg_ack  out  1  one-cycle completion pulse to debug
o_rsp_rdata  out  64  read data, valid with ack
o_rsp_err  out  1  error flag, valid with ack
o_ef_cmd_read  out  1  to controller read command
o_ef_cmd_pgm  out  1  to controller program command
o_ef_cmd_init  out  1  to controller init command
i_ef_read_done  in  1  controller done pulse
i_ef_rdata  in  64  controller output word
i_ef_read_fail  in  1  controller init-check fail
o_shadow  out  64  last good read word
o_shadow_vld  out  1  shadow valid
o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock `i_clk`; reset `i_rstn` is asynchronous, active-low.
- Reset: every output is 0.
  - State goes to BOOT if BOOT_EN = 1, else IDLE.
  - RR pointer is reset to "debug last", so host wins the first tie.
- States: IDLE, BOOT, ISSUE, WAIT_RD, WAIT_PGM, RESP, GAP. A 16-bit counter is shared and cleared on every state entry.
- BOOT: behaves as a read with no requester.
  - Goes to ISSUE (read) on the first cycle after reset.
  - No ack is generated.
  - On error, shadow stays invalid.
- IDLE arbitration:
  - If exactly one req is high, grant it.
  - If both are high, round-robin: grant the one not granted last; update the pointer on grant.
  - Latch the op and the requester id at grant.
  - Op 11 goes straight to RESP with err = 1; no command is issued.
- ISSUE: drive the matching cmd line high for exactly CMD_HOLD cycles, then drop it.
  - Read and init go to WAIT_RD.
  - Program goes to WAIT_PGM.
- WAIT_RD:
  - On i_ef_read_done, capture i_ef_rdata.
    - Read: err = 0; o_shadow <= data; o_shadow_vld <= 1.
    - Init: err = i_ef_read_fail; shadow is updated only if i_ef_read_fail = 0.
  - If the counter reaches RD_TIMEOUT first: err = 1, rdata = 0, shadow unchanged.
  - A done arriving in the same cycle as the timeout counts as success.
- WAIT_PGM: wait PGM_WAIT cycles, then go to RESP with err = 0, rdata = 0. o_shadow_vld is cleared on entry because the shadow is now stale.
- RESP: one cycle.
  - Ack pulses to the latched requester.
  - o_rsp_rdata and o_rsp_err hold their values until the next RESP.
  - Then go to GAP.
- GAP: all cmd lines low for GAP_CYC cycles, then IDLE (or to IDLE after BOOT).
- Request dropped mid-operation: the operation completes and the ack still pulses.
- A req must be seen low for at least one cycle after its ack before it is re-arbitrated.
- i_ef_read_done outside WAIT_RD is ignored.
- Only one cmd line is ever high at a time.
- Reset mid-operation: all cmd lines drop immediately; the sequence restarts from BOOT.

Optional Feature:
EFUSE_SCHED_PGM_LOCK_EN
- Defined: a sticky lock bit is set when a program op reaches RESP.
  - Any later program request goes directly to RESP with err = 1 and no command.
  - The lock is cleared only by reset.
- Undefined: no lock; program requests are always issued.

Test Plan:
- Boot read, controller done at cycle 30 with data 64'hDEAD_BEEF_0123_4567 -> o_ef_cmd_read high exactly 4 cycles; o_shadow = that value; o_shadow_vld = 1; no ack; o_busy low after GAP.
- Host and debug both request read in the same cycle after boot -> host acked first, then debug; the gap between the two command rises is at least 4 + 4 + response cycles; o_dbg_ack arrives after o_host_ack.
- Host program -> o_ef_cmd_pgm held 4 cycles; ack after 2047 wait cycles with err = 0; o_shadow_vld = 0.
- Debug init with i_ef_read_fail = 1 -> ack with o_rsp_err = 1; shadow unchanged.
- Host read with done never asserted -> ack after 1023 cycles; err = 1; rdata = 0.
- Host op 11 -> ack within 2 cycles, err = 1, no cmd line toggles.
- With EFUSE_SCHED_PGM_LOCK_EN defined: a second program request -> err = 1 and no o_ef_cmd_pgm edge.
